// File: rtl/dense_layer_sequencer.sv
// dense_layer_sequencer: runs one fully-connected layer out of a single-port 24-bit RAM.
// Define ARGMAX_EN to add class_id/class_valid (index of the largest output word).
module dense_layer_sequencer #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH = 24,
  parameter logic [ADDRESS_WIDTH-1:0] X_BASE = 14'h0000,
  parameter logic [ADDRESS_WIDTH-1:0] W_BASE = 14'h1000,
  parameter logic [ADDRESS_WIDTH-1:0] B_BASE = 14'h2EA0,
  parameter logic [ADDRESS_WIDTH-1:0] Y_BASE = 14'h3000,
  parameter int N_IN = 784,
  parameter int N_OUT = 10,
  parameter int OP_BITS = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_en,
  output logic [3:0]               ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata
`ifdef ARGMAX_EN
  ,
  output logic [3:0]               class_id,
  output logic                     class_valid
`endif
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int KW = $clog2(N_IN + 1);
  localparam int NW = (N_OUT > 1) ? $clog2(N_OUT + 1) : 1;
  localparam int PW = 2 * OP_BITS;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_B_RD,
    S_B_CAP,
    S_X_RD,
    S_W_RD,
    S_MAC,
    S_Y_WR,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NW-1:0]               n_q, n_d;
  logic [KW-1:0]               k_q, k_d;
  logic [AW-1:0]               w_ptr_q, w_ptr_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OP_BITS-1:0]          x_q, x_d;

  logic                        k_last;
  logic                        n_last;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic [DW-1:0]               sat_y;

  assign k_last = (k_q == KW'(N_IN - 1));
  assign n_last = (n_q == NW'(N_OUT - 1));

  assign prod = $signed(x_q) * $signed(ram_rdata[OP_BITS-1:0]);
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  assign sat_y = (acc_q > SAT_MAX) ? SAT_POS :
                 (acc_q < SAT_MIN) ? SAT_NEG :
                 acc_q[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_B_RD;
      S_B_RD:  state_d = S_B_CAP;
      S_B_CAP: state_d = S_X_RD;
      S_X_RD:  state_d = S_W_RD;
      S_W_RD:  state_d = S_MAC;
      S_MAC:   state_d = k_last ? S_Y_WR : S_X_RD;
      S_Y_WR:  state_d = n_last ? S_DONE : S_B_RD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and status are pure decodes of registered state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    ram_en    = 1'b0;
    ram_we    = 4'h0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      S_B_RD: begin
        ram_en   = 1'b1;
        ram_addr = B_BASE + AW'(n_q);
      end
      S_X_RD: begin
        ram_en   = 1'b1;
        ram_addr = X_BASE + AW'(k_q);
      end
      S_W_RD: begin
        ram_en   = 1'b1;
        ram_addr = W_BASE + w_ptr_q;
      end
      S_Y_WR: begin
        ram_en    = 1'b1;
        ram_we    = 4'hF;
        ram_addr  = Y_BASE + AW'(n_q);
        ram_wdata = sat_y;
      end
      default: ;
    endcase
  end

  // W is contiguous across neurons, so one running pointer covers n*N_IN+k.
  always_comb begin
    n_d     = n_q;
    k_d     = k_q;
    w_ptr_d = w_ptr_q;
    acc_d   = acc_q;
    x_d     = x_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = '0;
          k_d     = '0;
          w_ptr_d = '0;
        end
      end
      S_B_CAP: begin
        acc_d = {{(ACC_WIDTH-DW){ram_rdata[DW-1]}}, ram_rdata};
      end
      S_W_RD: begin
        x_d = ram_rdata[OP_BITS-1:0];
      end
      S_MAC: begin
        acc_d   = acc_q + prod_ext;
        k_d     = k_q + KW'(1);
        w_ptr_d = w_ptr_q + AW'(1);
      end
      S_Y_WR: begin
        k_d = '0;
        n_d = n_q + NW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q     <= '0;
      k_q     <= '0;
      w_ptr_q <= '0;
      acc_q   <= '0;
      x_q     <= '0;
    end else begin
      n_q     <= n_d;
      k_q     <= k_d;
      w_ptr_q <= w_ptr_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
    end
  end

`ifdef ARGMAX_EN
  logic signed [DW-1:0] max_q, max_d;
  logic [3:0]           cid_q, cid_d;
  logic                 cv_q, cv_d;

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    max_d = max_q;
    cid_d = cid_q;
    cv_d  = cv_q;
    if (state_q == S_IDLE && start) begin
      cv_d = 1'b0;
    end
    if (state_q == S_Y_WR) begin
      if (n_q == '0 || $signed(sat_y) > max_q) begin
        max_d = $signed(sat_y);
        cid_d = 4'(n_q);
      end
      if (n_last) begin
        cv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      cid_q <= '0;
      cv_q  <= 1'b0;
    end else begin
      max_q <= max_d;
      cid_q <= cid_d;
      cv_q  <= cv_d;
    end
  end

  assign class_id    = cid_q;
  assign class_valid = cv_q;
`endif

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Testbench for dense_layer_sequencer: RAM model, bus monitor and arithmetic reference.
// Build with +define+ARGMAX_EN to also check class_id/class_valid.
module tb_dense_layer_sequencer;

  localparam int AW = 14;
  localparam int DW = 24;
  localparam int N_IN = 784;
  localparam int N_OUT = 10;
  localparam int NEURON = 2 + 3 * N_IN + 1;
  localparam int DONE_CYC = N_OUT * NEURON + 1;
  localparam int XB = 'h0000;
  localparam int WB = 'h1000;
  localparam int BB = 'h2EA0;
  localparam int YB = 'h3000;

  logic clk = 1'b0;
  logic rst, start, busy, done, ram_en;
  logic [3:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
`ifdef ARGMAX_EN
  logic [3:0] class_id;
  logic class_valid;
  logic cv_first, cv_done;
  logic [3:0] cid_done;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] xv [N_IN];
  logic [DW-1:0] wv [N_IN*N_OUT];
  logic [DW-1:0] bv [N_OUT];

  int checks = 0;
  int failures = 0;
  int cyc, done_cyc, wr_cnt, bad_acc, busy_drop;
  bit rec = 1'b0;
  int tr_q[$];
  int wa_q[$];

  dense_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef ARGMAX_EN
    , .class_id(class_id), .class_valid(class_valid)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'hF) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (rec) begin
      if (ram_en)
        tr_q.push_back((1 << 20) | (int'(ram_we) << 16) | int'(ram_addr));
      else
        tr_q.push_back(int'(ram_we) << 16);
    end
    if (ram_en && ram_we == 4'hF) begin
      wr_cnt++;
      wa_q.push_back(int'(ram_addr));
      if (int'(ram_addr) < YB || int'(ram_addr) >= YB + N_OUT) bad_acc++;
    end
    if (ram_en && ram_we == 4'h0 && int'(ram_addr) >= YB) bad_acc++;
    if (ram_we != 4'h0 && ram_we != 4'hF) bad_acc++;
  end

  function automatic logic [23:0] model_y(int n);
    int acc, xs, ws;
    logic [7:0] xb, wb;
    logic signed [23:0] bs;
    bs = bv[n];
    acc = bs;
    for (int k = 0; k < N_IN; k++) begin
      xb = xv[k][7:0];
      wb = wv[n*N_IN+k][7:0];
      xs = $signed(xb);
      ws = $signed(wb);
      acc += xs * ws;
    end
    if (acc > 8388607) return 24'h7FFFFF;
    if (acc < -8388608) return 24'h800000;
    return acc[23:0];
  endfunction

  function automatic int model_argmax();
    int best, bi, v;
    logic signed [23:0] s;
    bi = 0;
    s = model_y(0);
    best = s;
    for (int n = 1; n < N_OUT; n++) begin
      s = model_y(n);
      v = s;
      if (v > best) begin
        best = v;
        bi = n;
      end
    end
    return bi;
  endfunction

  task automatic load_mem();
    for (int k = 0; k < N_IN; k++) mem[XB+k] = xv[k];
    for (int i = 0; i < N_IN*N_OUT; i++) mem[WB+i] = wv[i];
    for (int n = 0; n < N_OUT; n++) mem[BB+n] = bv[n];
    for (int n = 0; n < N_OUT; n++) mem[YB+n] = 24'h5A5A5A;
  endtask

  task automatic run_layer(input bit pulse_mid, input bit start_at_done);
    wr_cnt = 0;
    bad_acc = 0;
    busy_drop = 0;
    done_cyc = -1;
    wa_q.delete();
    tr_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    rec = 1'b1;
`ifdef ARGMAX_EN
    cv_first = class_valid;
`endif
    while (cyc <= DONE_CYC + 50) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) busy_drop++;
      if (pulse_mid && cyc == 500) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
`ifdef ARGMAX_EN
    cv_done = class_valid;
    cid_done = class_id;
`endif
    if (start_at_done) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rec = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (ram_en !== 1'b0 || ram_we !== 4'h0) begin
      failures++;
      $display("FAIL reset_bus got en=%b we=%h exp en=0 we=0", ram_en, ram_we);
    end
    checks++;
    if (ram_addr !== '0 || ram_wdata !== '0) begin
      failures++;
      $display("FAIL reset_addr_data got addr=%h wdata=%h exp 0/0", ram_addr, ram_wdata);
    end
`ifdef ARGMAX_EN
    checks++;
    if (class_id !== 4'd0 || class_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_class got id=%0d v=%b exp 0/0", class_id, class_valid);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_x();
`ifdef ARGMAX_EN
    logic [23:0] bpat [N_OUT];
    bpat = '{24'd0, 24'd5, 24'd3, 24'd9, 24'd9, 24'd1, 24'd2, 24'd4, 24'd6, 24'd7};
`endif
    for (int k = 0; k < N_IN; k++) xv[k] = 24'h0;
    for (int i = 0; i < N_IN*N_OUT; i++) wv[i] = 24'($urandom);
`ifdef ARGMAX_EN
    for (int n = 0; n < N_OUT; n++) bv[n] = bpat[n];
`else
    for (int n = 0; n < N_OUT; n++) bv[n] = 24'(n);
`endif
    load_mem();
    run_layer(1'b0, 1'b0);
    for (int n = 0; n < N_OUT; n++) begin
      checks++;
      if (mem[YB+n] !== model_y(n)) begin
        failures++;
        $display("FAIL zx_y[%0d] got=%h exp=%h", n, mem[YB+n], model_y(n));
      end
    end
    checks++;
    if (done_cyc != DONE_CYC) begin
      failures++;
      $display("FAIL zx_done_cycle got=%0d exp=%0d", done_cyc, DONE_CYC);
    end
    checks++;
    if (wr_cnt != N_OUT) begin
      failures++;
      $display("FAIL zx_writes got=%0d exp=%0d", wr_cnt, N_OUT);
    end
    checks++;
    if (bad_acc != 0 || busy_drop != 0) begin
      failures++;
      $display("FAIL zx_bus got bad=%0d busy_drop=%0d exp 0/0", bad_acc, busy_drop);
    end
`ifdef ARGMAX_EN
    checks++;
    if (cv_done !== 1'b1 || cid_done !== 4'(model_argmax())) begin
      failures++;
      $display("FAIL zx_argmax got id=%0d v=%b exp id=%0d v=1", cid_done, cv_done, model_argmax());
    end
    checks++;
    if (class_valid !== 1'b1 || class_id !== 4'(model_argmax())) begin
      failures++;
      $display("FAIL zx_argmax_hold got id=%0d v=%b exp id=%0d v=1", class_id, class_valid, model_argmax());
    end
`endif
  endtask

  task automatic test_unit_trace();
    int exp_q[$];
    int bad_i;
    for (int k = 0; k < N_IN; k++) xv[k] = 24'd1;
    for (int i = 0; i < N_IN*N_OUT; i++) wv[i] = 24'd1;
    for (int n = 0; n < N_OUT; n++) bv[n] = 24'd0;
    load_mem();
    run_layer(1'b1, 1'b1);
    for (int n = 0; n < N_OUT; n++) begin
      checks++;
      if (mem[YB+n] !== 24'd784) begin
        failures++;
        $display("FAIL unit_y[%0d] got=%h exp=%h", n, mem[YB+n], 24'd784);
      end
    end
    for (int n = 0; n < N_OUT; n++) begin
      exp_q.push_back((1 << 20) | (BB + n));
      exp_q.push_back(0);
      for (int k = 0; k < N_IN; k++) begin
        exp_q.push_back((1 << 20) | (XB + k));
        exp_q.push_back((1 << 20) | (WB + n*N_IN + k));
        exp_q.push_back(0);
      end
      exp_q.push_back((1 << 20) | (15 << 16) | (YB + n));
    end
    exp_q.push_back(0);
    bad_i = -1;
    for (int i = 0; i < tr_q.size(); i++) begin
      if (bad_i < 0 && tr_q[i] != ((i < exp_q.size()) ? exp_q[i] : 0)) bad_i = i;
    end
    if (bad_i < 0 && tr_q.size() < exp_q.size()) bad_i = tr_q.size();
    checks++;
    if (bad_i >= 0) begin
      failures++;
      $display("FAIL unit_trace first bad cycle=%0d got=%h exp=%h", bad_i + 1,
               (bad_i < tr_q.size()) ? tr_q[bad_i] : -1,
               (bad_i < exp_q.size()) ? exp_q[bad_i] : 0);
    end
    checks++;
    if (done_cyc != DONE_CYC || wr_cnt != N_OUT) begin
      failures++;
      $display("FAIL unit_single_run got done=%0d wr=%0d exp done=%0d wr=%0d",
               done_cyc, wr_cnt, DONE_CYC, N_OUT);
    end
    bad_i = -1;
    for (int i = 0; i < wa_q.size(); i++) if (bad_i < 0 && wa_q[i] != YB + i) bad_i = i;
    checks++;
    if (bad_i >= 0) begin
      failures++;
      $display("FAIL unit_wr_order idx=%0d got=%h exp=%h", bad_i, wa_q[bad_i], YB + bad_i);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL unit_idle_after got busy=%b exp=0", busy);
    end
`ifdef ARGMAX_EN
    checks++;
    if (cv_first !== 1'b0 || cid_done !== 4'd0 || cv_done !== 1'b1) begin
      failures++;
      $display("FAIL unit_argmax got first_v=%b id=%0d v=%b exp 0/0/1", cv_first, cid_done, cv_done);
    end
`endif
  endtask

  task automatic test_random_sat();
    logic [7:0] xb;
    for (int k = 0; k < N_IN; k++) xv[k] = 24'($urandom);
    for (int i = 0; i < N_IN*N_OUT; i++) wv[i] = 24'($urandom);
    for (int k = 0; k < N_IN; k++) begin
      xb = xv[k][7:0];
      wv[k] = {16'($urandom), xb[7] ? 8'h80 : 8'h7F};
      wv[N_IN+k] = {16'($urandom), xb[7] ? 8'h7F : 8'h80};
    end
    for (int n = 0; n < N_OUT; n++) bv[n] = 24'($urandom);
    bv[0] = 24'h7FFF00;
    bv[1] = 24'h800000;
    load_mem();
    run_layer(1'b0, 1'b0);
    checks++;
    if (model_y(0) !== 24'h7FFFFF || mem[YB] !== 24'h7FFFFF) begin
      failures++;
      $display("FAIL rnd_sat_pos got=%h model=%h exp=7fffff", mem[YB], model_y(0));
    end
    checks++;
    if (model_y(1) !== 24'h800000 || mem[YB+1] !== 24'h800000) begin
      failures++;
      $display("FAIL rnd_sat_neg got=%h model=%h exp=800000", mem[YB+1], model_y(1));
    end
    for (int n = 2; n < N_OUT; n++) begin
      checks++;
      if (mem[YB+n] !== model_y(n)) begin
        failures++;
        $display("FAIL rnd_y[%0d] got=%h exp=%h", n, mem[YB+n], model_y(n));
      end
    end
    checks++;
    if (done_cyc != DONE_CYC || wr_cnt != N_OUT || bad_acc != 0) begin
      failures++;
      $display("FAIL rnd_run got done=%0d wr=%0d bad=%0d exp done=%0d wr=%0d bad=0",
               done_cyc, wr_cnt, bad_acc, DONE_CYC, N_OUT);
    end
`ifdef ARGMAX_EN
    checks++;
    if (cid_done !== 4'(model_argmax())) begin
      failures++;
      $display("FAIL rnd_argmax got=%0d exp=%0d", cid_done, model_argmax());
    end
`endif
  endtask

  task automatic test_reset_midrun();
    mem[YB] = 24'hABCDEF;
    wr_cnt = 0;
    bad_acc = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_running got busy=%b exp=1", busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ram_en !== 1'b0 || ram_we !== 4'h0) begin
      failures++;
      $display("FAIL rst_idle got busy=%b done=%b en=%b we=%h exp 0/0/0/0",
               busy, done, ram_en, ram_we);
    end
    repeat (2000) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt != 0 || mem[YB] !== 24'hABCDEF || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_write got wr=%0d y0=%h busy=%b exp 0/abcdef/0", wr_cnt, mem[YB], busy);
    end
`ifdef ARGMAX_EN
    checks++;
    if (class_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_class_valid got=%b exp=0", class_valid);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_zero_x();
    test_unit_trace();
    test_random_sat();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
